// File: rtl/adsr_vca.sv
// Per-voice ADSR envelope generator followed by a VCA multiplier.
// The envelope is stepped once per audio frame, on each rising edge of lrclk.
module adsr_vca #(
  parameter int BITSIZE  = 16,
  parameter int ENVSIZE  = 16,
  parameter int RATESIZE = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       lrclk,
  input  logic                       gate,
  input  logic [RATESIZE-1:0]        attack_rate,
  input  logic [RATESIZE-1:0]        decay_rate,
  input  logic [RATESIZE-1:0]        release_rate,
  input  logic [ENVSIZE-1:0]         sustain_level,
  input  logic signed [BITSIZE-1:0]  sample_in,
  output logic signed [BITSIZE-1:0]  sample_out,
  output logic                       sample_valid,
  output logic [ENVSIZE-1:0]         env_level,
  output logic [2:0]                 state
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ATTACK  = 3'd1,
    DECAY   = 3'd2,
    SUSTAIN = 3'd3,
    RELEASE = 3'd4
  } state_t;

  localparam int PW = BITSIZE + ENVSIZE + 1;
  localparam logic [ENVSIZE:0] ENV_MAX = {1'b0, {ENVSIZE{1'b1}}};

  state_t                      st;
  state_t                      st_next;
  logic [ENVSIZE-1:0]          env;
  logic [ENVSIZE-1:0]          env_next;
  logic                        lr_s1;
  logic                        lr_s2;
  logic                        lr_prev;
  logic                        tick;
  logic                        vca_pending;
  logic signed [BITSIZE-1:0]   cap_sample;

  logic [ENVSIZE:0]            env_x;
  logic [ENVSIZE:0]            atk_x;
  logic [ENVSIZE:0]            dec_x;
  logic [ENVSIZE:0]            rel_x;
  logic [ENVSIZE:0]            sus_x;
  logic [ENVSIZE:0]            atk_sum;
  logic [ENVSIZE:0]            dec_diff;
  logic [ENVSIZE:0]            rel_diff;
  logic signed [PW-1:0]        product;
  logic                        unused_product;

  assign tick = lr_s2 & ~lr_prev;

  // All envelope arithmetic is done one bit wider so over/underflow is visible.
  assign env_x    = {1'b0, env};
  assign atk_x    = {{(ENVSIZE+1-RATESIZE){1'b0}}, attack_rate};
  assign dec_x    = {{(ENVSIZE+1-RATESIZE){1'b0}}, decay_rate};
  assign rel_x    = {{(ENVSIZE+1-RATESIZE){1'b0}}, release_rate};
  assign sus_x    = {1'b0, sustain_level};
  assign atk_sum  = env_x + atk_x;
  assign dec_diff = env_x - dec_x;
  assign rel_diff = env_x - rel_x;

  always_comb begin
    st_next  = st;
    env_next = env;
    case (st)
      IDLE: begin
        env_next = '0;
        if (gate) st_next = ATTACK;
      end
      ATTACK: begin
        if (!gate) begin
          st_next = RELEASE;
        end else if (atk_sum >= ENV_MAX) begin
          env_next = ENV_MAX[ENVSIZE-1:0];
          st_next  = DECAY;
        end else begin
          env_next = atk_sum[ENVSIZE-1:0];
        end
      end
      DECAY: begin
        if (!gate) begin
          st_next = RELEASE;
        end else if (dec_diff[ENVSIZE] || (dec_diff <= sus_x)) begin
          env_next = sustain_level;
          st_next  = SUSTAIN;
        end else begin
          env_next = dec_diff[ENVSIZE-1:0];
        end
      end
      SUSTAIN: begin
        if (!gate) st_next = RELEASE;
        else       env_next = sustain_level;
      end
      RELEASE: begin
        if (gate) begin
          st_next = ATTACK;
        end else if (rel_diff[ENVSIZE] || (rel_diff == '0)) begin
          env_next = '0;
          st_next  = IDLE;
        end else begin
          env_next = rel_diff[ENVSIZE-1:0];
        end
      end
      default: begin
        env_next = '0;
        st_next  = IDLE;
      end
    endcase
  end

  // The envelope is treated as a non-negative signed factor.
  assign product        = PW'(cap_sample) * PW'($signed({1'b0, env}));
  assign unused_product = ^{product[PW-1], product[ENVSIZE-1:0]};

  always_ff @(posedge clk) begin
    if (reset) begin
      st           <= IDLE;
      env          <= '0;
      lr_s1        <= 1'b0;
      lr_s2        <= 1'b0;
      lr_prev      <= 1'b0;
      vca_pending  <= 1'b0;
      cap_sample   <= '0;
      sample_out   <= '0;
      sample_valid <= 1'b0;
    end else begin
      lr_s1        <= lrclk;
      lr_s2        <= lr_s1;
      lr_prev      <= lr_s2;
      vca_pending  <= tick;
      sample_valid <= vca_pending;
      if (vca_pending) sample_out <= product[ENVSIZE +: BITSIZE];
      if (tick) begin
        st         <= st_next;
        env        <= env_next;
        cap_sample <= sample_in;
      end else if (st > RELEASE) begin
        st  <= IDLE;
        env <= '0;
      end
    end
  end

  assign env_level = env;
  assign state     = st;

endmodule

// File: tb/tb_adsr_vca.sv
// Randomized and directed bench for adsr_vca, checked frame by frame against
// an arithmetic envelope model.
module tb_adsr_vca;

  localparam int BITSIZE  = 16;
  localparam int ENVSIZE  = 16;
  localparam int RATESIZE = 8;
  localparam int ENV_MAX  = (1 << ENVSIZE) - 1;

  localparam int M_IDLE    = 0;
  localparam int M_ATTACK  = 1;
  localparam int M_DECAY   = 2;
  localparam int M_SUSTAIN = 3;
  localparam int M_RELEASE = 4;

  logic                      clk;
  logic                      reset;
  logic                      lrclk;
  logic                      gate;
  logic [RATESIZE-1:0]       attack_rate;
  logic [RATESIZE-1:0]       decay_rate;
  logic [RATESIZE-1:0]       release_rate;
  logic [ENVSIZE-1:0]        sustain_level;
  logic signed [BITSIZE-1:0] sample_in;
  logic signed [BITSIZE-1:0] sample_out;
  logic                      sample_valid;
  logic [ENVSIZE-1:0]        env_level;
  logic [2:0]                state;

  int     n_checks = 0;
  int     n_fails  = 0;
  int     m_state  = M_IDLE;
  int     m_env    = 0;
  longint m_out    = 0;

  adsr_vca #(.BITSIZE(BITSIZE), .ENVSIZE(ENVSIZE), .RATESIZE(RATESIZE)) dut (
    .clk           (clk),
    .reset         (reset),
    .lrclk         (lrclk),
    .gate          (gate),
    .attack_rate   (attack_rate),
    .decay_rate    (decay_rate),
    .release_rate  (release_rate),
    .sustain_level (sustain_level),
    .sample_in     (sample_in),
    .sample_out    (sample_out),
    .sample_valid  (sample_valid),
    .env_level     (env_level),
    .state         (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // One frame of the envelope, straight from the ADSR rules on plain integers.
  task automatic modelTick();
    int d;
    case (m_state)
      M_IDLE: begin
        m_env = 0;
        if (gate) m_state = M_ATTACK;
      end
      M_ATTACK: begin
        if (!gate) m_state = M_RELEASE;
        else begin
          d = m_env + int'(attack_rate);
          if (d >= ENV_MAX) begin m_env = ENV_MAX; m_state = M_DECAY; end
          else m_env = d;
        end
      end
      M_DECAY: begin
        if (!gate) m_state = M_RELEASE;
        else begin
          d = m_env - int'(decay_rate);
          if (d <= int'(sustain_level)) begin m_env = int'(sustain_level); m_state = M_SUSTAIN; end
          else m_env = d;
        end
      end
      M_SUSTAIN: begin
        if (!gate) m_state = M_RELEASE;
        else m_env = int'(sustain_level);
      end
      default: begin
        if (gate) m_state = M_ATTACK;
        else begin
          d = m_env - int'(release_rate);
          if (d <= 0) begin m_env = 0; m_state = M_IDLE; end
          else m_env = d;
        end
      end
    endcase
    m_out = (longint'(int'(sample_in)) * longint'(m_env)) >>> ENVSIZE;
  endtask

  // Runs one lrclk frame, scrambling inputs once they should have been captured.
  task automatic applyStimulus();
    logic                      sv_gate;
    logic [RATESIZE-1:0]       sv_atk, sv_dec, sv_rel;
    logic [ENVSIZE-1:0]        sv_sus;
    logic signed [BITSIZE-1:0] sv_smp;
    int lat;
    @(negedge clk);
    lrclk = 1'b1;
    sv_gate = gate; sv_atk = attack_rate; sv_dec = decay_rate;
    sv_rel = release_rate; sv_sus = sustain_level; sv_smp = sample_in;
    modelTick();
    lat = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 3) begin
        gate          = 1'($urandom_range(0, 1));
        attack_rate   = 8'($urandom);
        decay_rate    = 8'($urandom);
        release_rate  = 8'($urandom);
        sustain_level = 16'($urandom);
        sample_in     = 16'($urandom);
      end
      if (sample_valid) begin
        lat = k;
        break;
      end
    end
    checkOutput("valid_latency", lat, 4);
    checkOutput("env_level", env_level, m_env);
    checkOutput("state", state, m_state);
    checkOutput("sample_out", sample_out, m_out);
    @(negedge clk);
    checkOutput("valid_pulse", sample_valid, 0);
    lrclk = 1'b0;
    gate = sv_gate; attack_rate = sv_atk; decay_rate = sv_dec;
    release_rate = sv_rel; sustain_level = sv_sus; sample_in = sv_smp;
    repeat (3) @(negedge clk);
  endtask

  task automatic runUntil(input int target, input int budget);
    for (int i = 0; i < budget && m_state != target; i++) applyStimulus();
    checkOutput("reach_state", state, target);
  endtask

  initial begin
    reset = 1'b1; lrclk = 1'b0; gate = 1'b1;
    attack_rate = 8'hFF; decay_rate = 8'h10; release_rate = 8'h20;
    sustain_level = 16'h8000; sample_in = 16'h4000;

    for (int i = 0; i < 10; i++) begin
      lrclk = i[1];
      @(negedge clk);
      checkOutput("reset_sample_out", sample_out, 0);
      checkOutput("reset_valid", sample_valid, 0);
      checkOutput("reset_state", state, 0);
    end
    lrclk = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    $display("[TB] attack saturation");
    repeat (258) applyStimulus();
    checkOutput("attack_peak_env", env_level, 16'hFFFF);
    checkOutput("attack_peak_state", state, M_DECAY);

    $display("[TB] decay to sustain");
    runUntil(M_SUSTAIN, 2100);
    checkOutput("sustain_env", env_level, 16'h8000);
    checkOutput("sustain_vca", sample_out, 16'h2000);
    sustain_level = 16'h4000;
    applyStimulus();
    checkOutput("sustain_track", env_level, 16'h4000);

    $display("[TB] release");
    gate = 1'b0; release_rate = 8'hFF;
    runUntil(M_IDLE, 200);
    gate = 1'b1; attack_rate = 8'h40;
    repeat (65) applyStimulus();
    checkOutput("attack_env_1000", env_level, 16'h1000);
    gate = 1'b0; release_rate = 8'h20;
    applyStimulus();
    checkOutput("release_entry_state", state, M_RELEASE);
    repeat (128) applyStimulus();
    checkOutput("release_end_env", env_level, 0);
    checkOutput("release_end_state", state, M_IDLE);
    checkOutput("release_end_out", sample_out, 0);

    $display("[TB] retrigger");
    gate = 1'b1; attack_rate = 8'h40;
    repeat (33) applyStimulus();
    gate = 1'b0;
    applyStimulus();
    gate = 1'b1;
    applyStimulus();
    checkOutput("retrigger_state", state, M_ATTACK);
    checkOutput("retrigger_env", env_level, 16'h0800);
    applyStimulus();
    checkOutput("retrigger_climb", env_level, 16'h0840);

    $display("[TB] extremes");
    sustain_level = 16'hFFFF; attack_rate = 8'hFF;
    runUntil(M_SUSTAIN, 400);
    sample_in = -16'sd32768;
    applyStimulus();
    checkOutput("vca_min", sample_out, -32768);
    sample_in = 16'sd32767;
    applyStimulus();
    checkOutput("vca_max", sample_out, 32766);

    $display("[TB] randomized frames");
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 5) == 0) gate = ~gate;
      attack_rate   = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      decay_rate    = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      release_rate  = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      sustain_level = 16'($urandom);
      sample_in     = 16'($urandom);
      applyStimulus();
    end

    $display("[TB] reset during sustain");
    gate = 1'b1; attack_rate = 8'hFF; decay_rate = 8'hFF; sustain_level = 16'h3000;
    runUntil(M_SUSTAIN, 600);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("midreset_state", state, 0);
    checkOutput("midreset_env", env_level, 0);
    checkOutput("midreset_valid", sample_valid, 0);
    checkOutput("midreset_out", sample_out, 0);
    lrclk = 1'b1;
    repeat (3) @(negedge clk);
    lrclk = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("postreset_state", state, 0);
    checkOutput("postreset_valid", sample_valid, 0);
    m_state = M_IDLE; m_env = 0;
    applyStimulus();
    checkOutput("postreset_attack", state, M_ATTACK);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/adsr_vca.md
Name: adsr_vca

Overview:
- Per-voice ADSR envelope generator and VCA (amplitude multiplier).
- Sits between the sine oscillator output and the I2S transmitter left/right channel inputs.
- Shapes each oscillator sample by an envelope stepped once per audio frame (rising edge of lrclk).
- Driven by a note gate from the sequencer/button logic.

Parameters:
- BITSIZE, 16, width of signed audio samples in and out.
- ENVSIZE, 16, width of unsigned envelope accumulator; full scale is 2^ENVSIZE-1.
- RATESIZE, 8, width of attack/decay/release rate inputs.

Ports:
- clk  input  1  system clock (e.g. MCLK 12.288 MHz); must be faster than 4x lrclk.
- reset  input  1  synchronous, active-high reset.
- lrclk  input  1  DAC frame clock from codec; asynchronous to clk.
- gate  input  1  note on (1) / off (0).
- attack_rate  input  RATESIZE  envelope increment per frame in ATTACK.
- decay_rate  input  RATESIZE  decrement per frame in DECAY.
- release_rate  input  RATESIZE  decrement per frame in RELEASE.
- sustain_level  input  ENVSIZE  sustain target, unsigned.
- sample_in  input  BITSIZE  signed oscillator sample.
- sample_out  output  BITSIZE  signed enveloped sample, registered.
- sample_valid  output  1  one-clk pulse when sample_out updates.
- env_level  output  ENVSIZE  current envelope value.
- state  output  3  IDLE=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4.

Behaviour:
- Tick generation:
  - lrclk passes through a 2-flop synchronizer, then a rising-edge detector.
  - The detector produces tick, one clk wide.
  - The edge-detector history flop resets to 0, so if lrclk is high when reset releases, one tick may fire. This is legal.
- Sampling: on a tick cycle T, gate, all rate inputs, sustain_level and sample_in are captured. Between ticks they are ignored, so a gate pulse shorter than one frame may be missed.
- State update (registered at T+1). Rates are zero-extended to ENVSIZE.
  - IDLE: env=0. If gate=1, go to ATTACK; env stays 0 this tick.
  - ATTACK:
    - If gate=0, go to RELEASE with env unchanged.
    - Otherwise env+attack_rate; if the sum is >= max, set env=max and go to DECAY.
    - attack_rate=0 holds env.
  - DECAY:
    - If gate=0, go to RELEASE.
    - Otherwise, if env-decay_rate <= sustain_level (including underflow), set env=sustain_level and go to SUSTAIN; else env-=decay_rate.
    - If sustain_level >= env on entry, snap to sustain_level and go to SUSTAIN.
  - SUSTAIN: env=sustain_level, tracking live changes each tick. If gate=0, go to RELEASE.
  - RELEASE:
    - If gate=1, go to ATTACK, continuing from the current env with no reset to 0.
    - Otherwise env-release_rate, floor 0; reaching 0 goes to IDLE.
    - release_rate=0 holds env.
  - No transition may produce env wrap-around; all arithmetic uses a saturating compare at ENVSIZE+1 bits.
- VCA (registered at T+2):
  - product = sample_in (signed) x {1'b0, env} (signed, ENVSIZE+1 bits), computed with the env value as updated at T+1.
  - sample_out = product arithmetically shifted right by ENVSIZE, truncated (floor) to BITSIZE. No overflow is possible.
  - sample_valid pulses high at T+2 only.
  - sample_out holds between updates.
- Latency: lrclk edge at pin -> tick is 2-3 clk; tick -> sample_out is 2 clk.
- Reset (synchronous, any state, mid-operation included), effective the next clk:
  - state=IDLE, env_level=0, sample_out=0, sample_valid=0, synchronizer and edge flops=0, captured inputs=0.
  - A tick coincident with reset is discarded.
- Unused state encodings 5-7 go to IDLE with env=0 on the next clk.

Test Plan:
- Reset/startup:
  - Stimulus: reset held 10 clk while lrclk toggles and gate=1.
  - Required: sample_out=0, sample_valid=0, state=0 throughout reset.
  - After release: first tick -> state=1, then env climbs by attack_rate per tick.
- Attack saturation:
  - Stimulus: attack_rate=0xFF, gate=1.
  - Required: env=0xFF*n after n ticks; at tick 257 env=0xFFFF and state=2. Never wraps.
- Decay/sustain and VCA:
  - Stimulus: decay_rate=0x10, sustain_level=0x8000, sample_in=0x4000.
  - Required: env falls 16 per tick, lands exactly 0x8000, state=3; sample_out=0x2000 with sample_valid pulse 2 clk after each tick.
  - Changing sustain_level to 0x4000 -> env=0x4000 next tick.
- Release:
  - Stimulus: gate=0 at env=0x1000 during ATTACK, release_rate=0x20.
  - Required: state=4 next tick; env=0 after 128 ticks, then state=0 and sample_out=0.
- Retrigger:
  - Stimulus: gate=1 during RELEASE at env=0x0800, attack_rate=0x40.
  - Required: state=1, env=0x0840 on the following tick (no drop to 0).
- Extremes and mid-operation reset:
  - env=0xFFFF with sample_in=-32768 -> sample_out=-32768; with sample_in=32767 -> sample_out=32766.
  - Reset asserted in SUSTAIN -> next clk state=0, env_level=0, sample_valid=0.
